// File: rtl/brpred_pkg.sv
// Shared defaults and entry layout for the branch-prediction queue.
// The BRANCH_PERF_CNT_EN macro (see branch_resolve) enables the performance counters.
package brpred_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic                    taken;
        logic [XLEN_DEFAULT-1:0] pc_alt;
    } brpred_entry_t;

endpackage

// File: rtl/brpred_fifo.sv
// Pointer-based in-order queue of outstanding predictions.
// A synchronous clear empties it in one cycle; pointers wrap modulo DEPTH.
module brpred_fifo
    import brpred_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = XLEN_DEFAULT + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution and mispredict recovery: compares ID outcomes with queued IF predictions.
// Define BRANCH_PERF_CNT_EN to build the saturating branch/mispredict counters.
module branch_resolve
    import brpred_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc_alt,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_taken,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            upd_valid,
    output logic            upd_taken,
    output logic            err_overflow,
    output logic            err_underflow,
    output logic [31:0]     cnt_branches,
    output logic [31:0]     cnt_mispred
);

    logic            full, empty;
    logic [XLEN:0]   head;
    logic            head_taken;
    logic [XLEN-1:0] head_pc_alt;
    logic            accept, do_res, mispred, do_pop, do_push;
    logic            set_overflow, set_underflow;

    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            upd_valid_q, upd_valid_d;
    logic            upd_taken_q, upd_taken_d;
    logic            err_overflow_q, err_overflow_d;
    logic            err_underflow_q, err_underflow_d;

    assign head_taken  = head[XLEN];
    assign head_pc_alt = head[XLEN-1:0];

    // A registered flush means the queue was just cleared, so that cycle accepts nothing.
    always_comb begin
        accept        = !stall && !flush_q;
        do_res        = accept && res_valid && !empty;
        mispred       = do_res && (res_taken != head_taken);
        do_pop        = do_res && !mispred;
        do_push       = accept && pred_valid && !mispred && (!full || do_pop);
        set_overflow  = accept && pred_valid && !mispred && full && !do_pop;
        set_underflow = accept && res_valid && empty;
    end

    brpred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (mispred),
        .push  (do_push),
        .pop   (do_pop),
        .wdata ({pred_taken, pred_pc_alt}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        flush_d         = mispred;
        redirect_pc_d   = mispred ? head_pc_alt : '0;
        upd_valid_d     = do_res;
        upd_taken_d     = do_res && res_taken;
        err_overflow_d  = err_overflow_q || set_overflow;
        err_underflow_d = err_underflow_q || set_underflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q         <= 1'b0;
            redirect_pc_q   <= '0;
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            upd_valid_q     <= upd_valid_d;
            upd_taken_q     <= upd_taken_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign pred_ready    = !full;
    assign flush         = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign upd_valid     = upd_valid_q;
    assign upd_taken     = upd_taken_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] cnt_branches_q, cnt_branches_d;
    logic [31:0] cnt_mispred_q, cnt_mispred_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt_branches_d = cnt_branches_q;
        cnt_mispred_d  = cnt_mispred_q;
        if (do_res && (cnt_branches_q != 32'hFFFF_FFFF)) begin
            cnt_branches_d = cnt_branches_q + 32'd1;
        end
        if (mispred && (cnt_mispred_q != 32'hFFFF_FFFF)) begin
            cnt_mispred_d = cnt_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branches_q <= '0;
            cnt_mispred_q  <= '0;
        end else begin
            cnt_branches_q <= cnt_branches_d;
            cnt_mispred_q  <= cnt_mispred_d;
        end
    end

    assign cnt_branches = cnt_branches_q;
    assign cnt_mispred  = cnt_mispred_q;
`else
    assign cnt_branches = '0;
    assign cnt_mispred  = '0;
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and misprediction-recovery unit, the consumer end of the IF-stage branch predictor. It records each prediction issued in IF in a small in-order queue. When the branch resolves in ID, it compares the actual outcome against the oldest recorded prediction. On a mismatch it issues a registered flush and redirect PC to the fetch stage, and it returns the true outcome to the predictor as a state-update strobe.

## Interface
Parameters:
- DEPTH, 2: in-flight prediction slots; power of 2, ≥2.
- XLEN, 32: PC width.

Ports (reset is asynchronous, active-high):
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all queue pushes, pops and updates.
- pred_valid  in  1  IF issues a predicted branch this cycle.
- pred_taken  in  1  predicted direction.
- pred_pc_alt  in  XLEN  PC to fetch if the prediction is wrong (PC+4 if predicted taken, target if predicted not-taken).
- pred_ready  out  1  queue not full.
- res_valid  in  1  branch resolved in ID this cycle.
- res_taken  in  1  actual outcome.
- flush  out  1  one-cycle mispredict pulse to IF/ID.
- redirect_pc  out  XLEN  fetch PC, valid when flush=1.
- upd_valid  out  1  one-cycle predictor update strobe.
- upd_taken  out  1  actual outcome for the predictor.
- err_overflow  out  1  sticky: push while full.
- err_underflow  out  1  sticky: resolve while empty.
- cnt_branches  out  32  resolved branches (BRANCH_PERF_CNT_EN only).
- cnt_mispred  out  32  mispredictions (BRANCH_PERF_CNT_EN only).

## Operation
- Queue entries hold {taken, pc_alt}. Entries are stored FIFO with read/write pointers and an occupancy count of width $clog2(DEPTH)+1.
- Accept cycle: stall=0 and flush=0. Inputs in any other cycle are ignored.
- Push: on an accept cycle with pred_valid=1 and the queue not full, write the entry.
- Push while full: the entry is dropped and err_overflow is set.
- Resolve: on an accept cycle with res_valid=1 and the queue non-empty, compare res_taken against head.taken and pop the head.
- Match: next cycle upd_valid=1 and upd_taken=res_taken; flush stays 0.
- Mismatch: next cycle flush=1, redirect_pc=head.pc_alt, upd_valid=1 and upd_taken=res_taken. The whole queue is cleared, because all younger entries are wrong-path.
- Resolve while empty: ignored; err_underflow is set.
- Simultaneous push and resolve:
  - Correct resolve: pop and push both occur, and occupancy is unchanged. A push at full is allowed only when the same cycle pops. pred_ready itself stays !full, with no combinational path from res_valid.
  - Mispredict: the same-cycle push is discarded (wrong-path). It does not set err_overflow.
- Flush cycle: all inputs are ignored. The queue is already empty.
- Error flags clear only on rst.

## Timing
- Reset values: every output is 0 except pred_ready=1; the queue is empty and pointers are 0.
- Reset is asynchronous and may occur mid-operation. All state clears immediately, including a pending flush.
- Latency from a res_valid accept edge:
  - flush, redirect_pc, upd_valid and upd_taken are registered and appear exactly 1 cycle later.
  - Each is high for exactly one cycle.
- pred_ready reflects the registered occupancy; it has no combinational input path.
- stall=1 in the cycle a flush/upd pulse is already registered: the pulse still completes.
- Pointers wrap modulo DEPTH.

## Configuration
- BRANCH_PERF_CNT_EN defined:
  - cnt_branches increments on each accepted non-empty resolve.
  - cnt_mispred increments on each mismatch.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- BRANCH_PERF_CNT_EN undefined: the counters are absent and both ports are tied to 0.

## Structure
- Package brpred_pkg holds the XLEN default, the DEPTH default, and the brpred_entry_t struct {taken, pc_alt}.
- Sub-module brpred_fifo:
  - Pointer-based queue with synchronous clear (flush), push/pop/full/empty, and a head read.
  - branch_resolve instantiates it and owns compare, flush and update generation, error flags and counters.

## Test plan
- Reset: assert rst mid-traffic -> all outputs 0 and pred_ready=1 immediately, with no flush after release.
- Correct prediction: push {taken=1, alt=0x104}, resolve res_taken=1 -> next cycle upd_valid=1, upd_taken=1, flush=0; queue empty.
- Mispredict: push {taken=0, alt=0x200}, push {1, 0x300}, resolve res_taken=1 -> next cycle flush=1, redirect_pc=0x200, upd_taken=1; queue empty; cnt_mispred=1.
- Full and overflow: with DEPTH=2, push twice -> pred_ready=0. Third push alone -> err_overflow=1, entry dropped. Then resolve both correctly -> two upd pulses, pred_ready=1.
- Stall: res_valid=1 with stall=1 for 3 cycles -> no upd and no pop. Release stall -> upd_valid one cycle later.
- Boundary cases:
  - Push plus mispredict in the same cycle -> pushed entry discarded, occupancy 0.
  - res_valid=1 during the flush cycle -> ignored; err_underflow stays 0.
  - res_valid with an empty queue -> err_underflow=1.
